// File: rtl/cfg_scan_chain_pkg.sv
// Shared types and helpers for the configuration scan chain.
package cfg_scan_chain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit offset of a lane's slice within the flattened parallel output.
   function automatic int unsigned lane_offset(input int unsigned lane, input int unsigned depth);
      return lane * depth;
   endfunction

endpackage

// File: rtl/cfg_scan_lane.sv
// One DEPTH-bit configuration shift lane; shift_out_c is the pre-shift MSB.
module cfg_scan_lane #(
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             shift_en,
   input  logic             sin,
   output logic [DEPTH-1:0] q,
   output logic             shift_out_c
);

   assign shift_out_c = q[DEPTH-1];

   // Newest bit enters at bit 0 so the first beat ends in the MSB.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (set) begin
         q <= '1;
      end else if (shift_en) begin
         q <= {q[DEPTH-2:0], sin};
      end
   end

endmodule

// File: rtl/cfg_scan_chain.sv
// Configuration scan chain: beat-counting load FSM, parallel lanes, serial readback.
module cfg_scan_chain
   import cfg_scan_chain_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned NUM_CHAINS = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        set,
   input  logic                        start,
   input  logic                        sin_valid,
   output logic                        sin_ready,
   input  logic [NUM_CHAINS-1:0]       sin_data,
   output logic                        sout_valid,
   output logic [NUM_CHAINS-1:0]       sout_data,
   output logic                        cfg_done,
   output logic [NUM_CHAINS*DEPTH-1:0] cfg_out
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_t                state, next_state;
   logic [CNT_W-1:0]      count, next_count;
   logic                  accept_c;
   logic [NUM_CHAINS-1:0] shift_out_c;

   // Next-state logic; set overrides start, start overrides a beat.
   always_comb begin
      next_state = state;
      next_count = count;
      accept_c   = 1'b0;
      if (set) begin
         next_state = IDLE;
         next_count = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  next_state = LOAD;
                  next_count = '0;
               end
            end
            LOAD: begin
               if (start) begin
                  next_count = '0;
               end else if (sin_valid && sin_ready) begin
                  accept_c = 1'b1;
                  if (count == CNT_W'(DEPTH - 1)) begin
                     next_state = DONE;
                     next_count = '0;
                  end else begin
                     next_count = count + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (start) begin
                  next_state = LOAD;
                  next_count = '0;
               end
            end
            default: begin
               next_state = IDLE;
               next_count = '0;
            end
         endcase
      end
   end

   // State register; ready/done are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         sin_ready <= 1'b0;
         cfg_done  <= 1'b0;
      end else begin
         state     <= next_state;
         count     <= next_count;
         sin_ready <= (next_state == LOAD);
         cfg_done  <= (next_state == DONE);
      end
   end

   // Readback: previous MSB of each lane, one cycle after the accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         sout_valid <= 1'b0;
         sout_data  <= '0;
      end else begin
         sout_valid <= accept_c;
         if (accept_c) begin
            sout_data <= shift_out_c;
         end
      end
   end

   for (genvar l = 0; l < NUM_CHAINS; l++) begin : g_lane
      cfg_scan_lane #(
         .DEPTH (DEPTH)
      ) u_lane (
         .clk         (clk),
         .reset       (reset),
         .set         (set),
         .shift_en    (accept_c),
         .sin         (sin_data[l]),
         .q           (cfg_out[lane_offset(l, DEPTH) +: DEPTH]),
         .shift_out_c (shift_out_c[l])
      );
   end

endmodule

// File: tb/tb_cfg_scan_chain.sv
// Directed self-checking bench for cfg_scan_chain with DEPTH=8, NUM_CHAINS=2.
module tb_cfg_scan_chain;

   localparam int unsigned DEPTH      = 8;
   localparam int unsigned NUM_CHAINS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        set;
   logic        start;
   logic        sin_valid;
   logic        sin_ready;
   logic [1:0]  sin_data;
   logic        sout_valid;
   logic [1:0]  sout_data;
   logic        cfg_done;
   logic [15:0] cfg_out;

   int total = 0;
   int bad   = 0;

   // Expected lane contents and beat count
   logic [7:0] m0, m1;
   int         cnt_m;

   cfg_scan_chain #(
      .DEPTH      (DEPTH),
      .NUM_CHAINS (NUM_CHAINS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .set        (set),
      .start      (start),
      .sin_valid  (sin_valid),
      .sin_ready  (sin_ready),
      .sin_data   (sin_data),
      .sout_valid (sout_valid),
      .sout_data  (sout_data),
      .cfg_done   (cfg_done),
      .cfg_out    (cfg_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt_m = 0;
      check("start_ready", 32'(sin_ready), 32'd1);
      check("start_done", 32'(cfg_done), 32'd0);
      check("start_sout_valid", 32'(sout_valid), 32'd0);
   endtask

   // Feed beats i=0..n-1 from bit 7-i of each pattern; gapped inserts two idle cycles between beats.
   task automatic load_beats(input logic [7:0] p0, input logic [7:0] p1, input int n, input bit gapped);
      logic [1:0]  exp_s;
      logic [15:0] hold;
      for (int i = 0; i < n; i++) begin
         if (gapped && i > 0) begin
            for (int g = 0; g < 2; g++) begin
               sin_valid = 1'b0;
               sin_data  = 2'b11;
               hold      = {m1, m0};
               tick();
               check("gap_sout_valid", 32'(sout_valid), 32'd0);
               check("gap_cfg_out", 32'(cfg_out), 32'(hold));
               check("gap_done", 32'(cfg_done), 32'd0);
            end
         end
         sin_valid = 1'b1;
         sin_data  = {p1[7-i], p0[7-i]};
         exp_s     = {m1[7], m0[7]};
         m0        = {m0[6:0], p0[7-i]};
         m1        = {m1[6:0], p1[7-i]};
         cnt_m++;
         tick();
         check("beat_sout_valid", 32'(sout_valid), 32'd1);
         check("beat_sout_data", 32'(sout_data), 32'(exp_s));
         check("beat_cfg_out", 32'(cfg_out), 32'({m1, m0}));
         check("beat_done", 32'(cfg_done), 32'(cnt_m == 8));
         check("beat_ready", 32'(sin_ready), 32'(cnt_m != 8));
         if (cnt_m == 8) cnt_m = 0;
      end
      sin_valid = 1'b0;
      sin_data  = 2'b00;
   endtask

   initial begin
      reset = 1'b1; set = 1'b0; start = 1'b0; sin_valid = 1'b0; sin_data = 2'b00;
      m0 = 8'h00; m1 = 8'h00; cnt_m = 0;

      // Reset sequence
      tick(); tick();
      reset = 1'b0;
      check("rst_cfg_out", 32'(cfg_out), 32'h0000);
      check("rst_done", 32'(cfg_done), 32'd0);
      check("rst_ready", 32'(sin_ready), 32'd0);
      check("rst_sout_valid", 32'(sout_valid), 32'd0);
      check("rst_sout_data", 32'(sout_data), 32'd0);

      // Beats in IDLE are ignored
      sin_valid = 1'b1; sin_data = 2'b11;
      tick();
      sin_valid = 1'b0;
      check("idle_beat_cfg", 32'(cfg_out), 32'h0000);
      check("idle_beat_sout", 32'(sout_valid), 32'd0);

      // Normal load
      start_load();
      load_beats(8'hB2, 8'hFF, 8, 1'b0);
      check("load_final", 32'(cfg_out), 32'hFFB2);
      check("load_done", 32'(cfg_done), 32'd1);

      // Beats in DONE are ignored
      sin_valid = 1'b1; sin_data = 2'b00;
      tick();
      sin_valid = 1'b0;
      check("done_beat_cfg", 32'(cfg_out), 32'hFFB2);
      check("done_beat_sout", 32'(sout_valid), 32'd0);
      check("done_hold", 32'(cfg_done), 32'd1);

      // Set then readback of all-ones
      set = 1'b1;
      tick();
      set = 1'b0;
      m0 = 8'hFF; m1 = 8'hFF;
      check("set_cfg_out", 32'(cfg_out), 32'hFFFF);
      check("set_done", 32'(cfg_done), 32'd0);
      check("set_ready", 32'(sin_ready), 32'd0);
      start_load();
      load_beats(8'h00, 8'h00, 8, 1'b0);
      check("set_rb_final", 32'(cfg_out), 32'h0000);

      // Gapped valid
      start_load();
      load_beats(8'h5C, 8'h0F, 8, 1'b1);
      check("gap_final", 32'(cfg_out), 32'h0F5C);
      check("gap_final_done", 32'(cfg_done), 32'd1);

      // Reset mid-load
      start_load();
      load_beats(8'hB2, 8'hFF, 3, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m0 = 8'h00; m1 = 8'h00;
      check("midrst_cfg", 32'(cfg_out), 32'h0000);
      check("midrst_done", 32'(cfg_done), 32'd0);
      check("midrst_ready", 32'(sin_ready), 32'd0);
      check("midrst_sout_valid", 32'(sout_valid), 32'd0);
      start_load();
      load_beats(8'hB2, 8'hFF, 8, 1'b0);
      check("midrst_reload", 32'(cfg_out), 32'hFFB2);

      // Restart in LOAD after 5 accepts; the beat alongside start is dropped
      start_load();
      load_beats(8'hC3, 8'h81, 5, 1'b0);
      start = 1'b1; sin_valid = 1'b1; sin_data = 2'b11;
      tick();
      start = 1'b0; sin_valid = 1'b0; sin_data = 2'b00;
      cnt_m = 0;
      check("restart_sout_valid", 32'(sout_valid), 32'd0);
      check("restart_cfg_hold", 32'(cfg_out), 32'({m1, m0}));
      check("restart_ready", 32'(sin_ready), 32'd1);
      check("restart_done", 32'(cfg_done), 32'd0);
      load_beats(8'h3C, 8'h5A, 8, 1'b0);
      check("restart_final", 32'(cfg_out), 32'h5A3C);

      // set beats start in the same cycle
      set = 1'b1; start = 1'b1;
      tick();
      set = 1'b0; start = 1'b0;
      check("set_start_cfg", 32'(cfg_out), 32'hFFFF);
      check("set_start_ready", 32'(sin_ready), 32'd0);
      check("set_start_done", 32'(cfg_done), 32'd0);

      // reset beats set in the same cycle
      reset = 1'b1; set = 1'b1;
      tick();
      reset = 1'b0; set = 1'b0;
      check("rst_set_cfg", 32'(cfg_out), 32'h0000);
      check("rst_set_ready", 32'(sin_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
